// File: rtl/dram_responder_if.sv
// Handshake bundle between the core's dram ports (master) and the DRAM responder (slave).
interface dram_responder_if #(
  parameter int unsigned ABW   = 10,
  parameter int unsigned DBW   = 16,
  parameter int unsigned CSIZE = 32
) ();
  logic                   ra_rdy;
  logic                   ra_ack;
  logic [ABW-1:0]         ra_addr;
  logic                   rd_rdy;
  logic                   rd_ack;
  logic [CSIZE*DBW-1:0]   rd_data;
  logic                   w_rdy;
  logic                   w_ack;
  logic [ABW-1:0]         w_addr;
  logic [CSIZE*DBW-1:0]   w_data;
  logic [CSIZE-1:0]       w_mask;

  modport master (
    output ra_rdy, ra_addr, rd_ack, w_rdy, w_addr, w_data, w_mask,
    input  ra_ack, rd_rdy, rd_data, w_ack
  );

  modport slave (
    input  ra_rdy, ra_addr, rd_ack, w_rdy, w_addr, w_data, w_mask,
    output ra_ack, rd_rdy, rd_data, w_ack
  );
endinterface

// File: rtl/dram_responder.sv
// DRAM-side line store with fixed-latency in-order line reads and masked line writes.
module dram_responder #(
  parameter int unsigned ABW    = 10,
  parameter int unsigned DBW    = 16,
  parameter int unsigned CSIZE  = 32,
  parameter int unsigned LAT    = 4,
  parameter int unsigned QDEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  dram_responder_if.slave          bus,
  input  logic                     i_ra_block,
  input  logic                     i_w_block,
  output logic [$clog2(QDEPTH):0]  o_pending
);
  localparam int unsigned PW    = $clog2(QDEPTH);
  localparam int unsigned CW    = PW + 1;
  localparam int unsigned LW    = CSIZE * DBW;
  localparam int unsigned DEPTH = 2 ** ABW;
  localparam logic [3:0]  CD_INIT = 4'(LAT - 1);

  logic [LW-1:0] store  [DEPTH];
  logic [LW-1:0] q_data [QDEPTH];
  logic [3:0]    q_cd   [QDEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  assign full        = (o_pending == CW'(QDEPTH));
  assign empty       = (o_pending == '0);
  assign bus.ra_ack  = bus.ra_rdy & ~full & ~i_ra_block & i_rst;
  assign bus.w_ack   = bus.w_rdy & ~i_w_block & i_rst;
  assign bus.rd_rdy  = ~empty & (q_cd[head] == 4'd0);
  assign bus.rd_data = q_data[head];
  assign push        = bus.ra_ack;
  assign pop         = bus.rd_rdy & bus.rd_ack;

  // Line store: not reset; masked per-word update
  always_ff @(posedge i_clk) begin
    if (bus.w_ack) begin
      for (int k = 0; k < CSIZE; k++) begin
        if (bus.w_mask[k]) begin
          store[bus.w_addr][k*DBW +: DBW] <= bus.w_data[k*DBW +: DBW];
        end
      end
    end
  end

  // Queue payload captures the pre-write line, so a same-cycle write is not seen
  always_ff @(posedge i_clk) begin
    if (push) begin
      q_data[tail] <= store[bus.ra_addr];
    end
  end

  // Queue pointers, occupancy and latency countdowns
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      head      <= '0;
      tail      <= '0;
      o_pending <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        q_cd[i] <= 4'd0;
      end
    end else begin
      for (int i = 0; i < QDEPTH; i++) begin
        if (q_cd[i] != 4'd0) begin
          q_cd[i] <= q_cd[i] - 4'd1;
        end
      end
      if (push) begin
        q_cd[tail] <= CD_INIT;
        tail       <= PW'(tail + PW'(1));
      end
      if (pop) begin
        head <= PW'(head + PW'(1));
      end
      o_pending <= CW'(o_pending + CW'(push) - CW'(pop));
    end
  end
endmodule
